// File: rtl/nco_seq_pkg.sv
// rtl/nco_seq_pkg.sv - shared types and helpers for the NCO front-panel sequencer
// Purpose: phase encoding seen on phase_out and counter-width helpers.
// Ports: none (package).
package nco_seq_pkg;

    typedef enum logic [1:0] {
        PH_BOOT    = 2'd0,
        PH_SELECT  = 2'd1,
        PH_DISPLAY = 2'd2,
        PH_RUN     = 2'd3
    } phase_t;

    // Width of a down-counter that must be able to hold max_cycles.
    function automatic int cnt_w(input int max_cycles);
        return $clog2(max_cycles) + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/nco_hold_timer.sv
// rtl/nco_hold_timer.sv - shared down-counter for the BOOT, DISPLAY and idle-timeout holds
// Purpose: loadable down-counter that stops at zero.
// Ports:
//   clk_1MHz  in   system clock
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val on this edge (has priority over tick)
//   load_val  in   W-bit value to load
//   tick      in   decrement by one (saturates at zero)
//   expired   out  count is zero
module nco_hold_timer #(
    parameter int W = 8
) (
    input  logic         clk_1MHz,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/nco_ui_sequencer.sv
// rtl/nco_ui_sequencer.sv - front-panel sequencer: boot hold, per-stage select/display, run
// Purpose: walks BOOT -> (SELECT, DISPLAY) x NUM_STAGES -> RUN and latches one
//   VAL_W-bit choice per stage into cfg_out. Optional SELECT idle timeout is
//   enabled by defining NCO_SEQ_TIMEOUT_EN.
// Ports:
//   clk_1MHz    in   system clock
//   rst         in   synchronous active-high reset
//   sel_strobe  in   pulse: accept sel_value for the current stage
//   sel_value   in   VAL_W value offered for the current stage
//   back        in   pulse: return to the previous stage while selecting
//   restart     in   pulse: RUN -> SELECT stage 0, cfg kept
//   phase_out   out  current phase (phase_t)
//   stage_out   out  current stage index
//   cfg_out     out  packed slots, slot k at [k*VAL_W +: VAL_W]
//   run         out  high exactly while phase_out is RUN
module nco_ui_sequencer
    import nco_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 2,
    parameter int VAL_W          = 3,
    parameter int BOOT_CYCLES    = 5000000,
    parameter int DISPLAY_CYCLES = 5000000,
    parameter int TIMEOUT_CYCLES = 30000000
) (
    input  logic                                clk_1MHz,
    input  logic                                rst,
    input  logic                                sel_strobe,
    input  logic [VAL_W-1:0]                    sel_value,
    input  logic                                back,
    input  logic                                restart,
    output phase_t                              phase_out,
    output logic [$clog2(NUM_STAGES):0]         stage_out,
    output logic [NUM_STAGES*VAL_W-1:0]         cfg_out,
    output logic                                run
);

    localparam int SW = $clog2(NUM_STAGES) + 1;
    localparam int CW = cnt_w(max3(BOOT_CYCLES, DISPLAY_CYCLES, TIMEOUT_CYCLES));

    phase_t                              phase, phase_n;
    logic [SW-1:0]                       stage, stage_n;
    logic [NUM_STAGES-1:0][VAL_W-1:0]    cfg, cfg_n;
    logic                                boot_armed, boot_armed_n;

    logic                                t_load;
    logic [CW-1:0]                       t_val;
    logic                                t_tick;
    logic                                t_expired;
    logic                                accept;

    nco_hold_timer #(.W(CW)) u_timer (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .tick     (t_tick),
        .expired  (t_expired)
    );

    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            phase      <= PH_BOOT;
            stage      <= '0;
            cfg        <= '0;
            boot_armed <= 1'b0;
            run        <= 1'b0;
        end else begin
            phase      <= phase_n;
            stage      <= stage_n;
            cfg        <= cfg_n;
            boot_armed <= boot_armed_n;
            run        <= (phase_n == PH_RUN);
        end
    end

    always_comb begin
        phase_n      = phase;
        stage_n      = stage;
        cfg_n        = cfg;
        boot_armed_n = boot_armed;
        t_load       = 1'b0;
        t_val        = '0;
        t_tick       = 1'b0;

`ifdef NCO_SEQ_TIMEOUT_EN
        accept = sel_strobe || (!back && t_expired);
`else
        accept = sel_strobe;
`endif

        case (phase)
            PH_BOOT: begin
                // The counter comes out of reset at zero, so the first BOOT
                // edge arms it; that edge already accounts for one hold cycle.
                if (!boot_armed) begin
                    if (BOOT_CYCLES == 1) begin
                        phase_n = PH_SELECT;
                        stage_n = '0;
                    end else begin
                        t_load       = 1'b1;
                        t_val        = CW'(BOOT_CYCLES - 2);
                        boot_armed_n = 1'b1;
                    end
                end else if (t_expired) begin
                    phase_n      = PH_SELECT;
                    stage_n      = '0;
                    boot_armed_n = 1'b0;
                end else begin
                    t_tick = 1'b1;
                end
            end
            PH_SELECT: begin
                if (accept) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (SW'(k) == stage) begin
                            cfg_n[k] = sel_value;
                        end
                    end
                    phase_n = PH_DISPLAY;
                    t_load  = 1'b1;
                    t_val   = CW'(DISPLAY_CYCLES - 1);
                end else if (back && (stage != '0)) begin
                    stage_n = stage - SW'(1);
                end
            end
            PH_DISPLAY: begin
                if (t_expired) begin
                    if (stage < SW'(NUM_STAGES - 1)) begin
                        stage_n = stage + SW'(1);
                        phase_n = PH_SELECT;
                    end else begin
                        phase_n = PH_RUN;
                    end
                end else begin
                    t_tick = 1'b1;
                end
            end
            PH_RUN: begin
                if (restart) begin
                    phase_n = PH_SELECT;
                    stage_n = '0;
                end
            end
            default: begin
                // Reload the full hold: this edge does not count as a BOOT cycle.
                phase_n      = PH_BOOT;
                t_load       = 1'b1;
                t_val        = CW'(BOOT_CYCLES - 1);
                boot_armed_n = 1'b1;
            end
        endcase

`ifdef NCO_SEQ_TIMEOUT_EN
        // Idle timer: restart on SELECT entry and on every back, else count
        // down while waiting in SELECT.
        if ((phase_n == PH_SELECT) && (phase != PH_SELECT)) begin
            t_load = 1'b1;
            t_val  = CW'(TIMEOUT_CYCLES - 1);
        end else if ((phase == PH_SELECT) && (phase_n == PH_SELECT)) begin
            if (back) begin
                t_load = 1'b1;
                t_val  = CW'(TIMEOUT_CYCLES - 1);
            end else begin
                t_tick = 1'b1;
            end
        end
`endif
    end

    assign phase_out = phase;
    assign stage_out = stage;
    assign cfg_out   = cfg;

endmodule

// File: tb/tb_nco_ui_sequencer.sv
// tb/tb_nco_ui_sequencer.sv - directed scoreboard bench for nco_ui_sequencer
module tb_nco_ui_sequencer;

    localparam int NS = 2;
    localparam int VW = 3;
    localparam int BC = 4;
    localparam int DC = 3;
    localparam int TC = 6;

    localparam int B = 0;
    localparam int S = 1;
    localparam int D = 2;
    localparam int R = 3;

    logic           clk_1MHz = 1'b0;
    logic           rst;
    logic           sel_strobe;
    logic [VW-1:0]  sel_value;
    logic           back;
    logic           restart;
    logic [1:0]     phase_out;
    logic [1:0]     stage_out;
    logic [NS*VW-1:0] cfg_out;
    logic           run;

    always #5 clk_1MHz = ~clk_1MHz;

    nco_ui_sequencer #(
        .NUM_STAGES     (NS),
        .VAL_W          (VW),
        .BOOT_CYCLES    (BC),
        .DISPLAY_CYCLES (DC),
        .TIMEOUT_CYCLES (TC)
    ) u_dut (
        .clk_1MHz   (clk_1MHz),
        .rst        (rst),
        .sel_strobe (sel_strobe),
        .sel_value  (sel_value),
        .back       (back),
        .restart    (restart),
        .phase_out  (phase_out),
        .stage_out  (stage_out),
        .cfg_out    (cfg_out),
        .run        (run)
    );

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input int s, input int v, input int b, input int rs);
        sel_strobe = s[0];
        sel_value  = v[VW-1:0];
        back       = b[0];
        restart    = rs[0];
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [10:0] obs;
        obs = {phase_out, stage_out, cfg_out, run};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed ph=%0d st=%0d cfg=%h run=%0d expected ph=%0d st=%0d cfg=%h run=%0d",
                       e.tag, obs[10:9], obs[8:7], obs[6:1], obs[0],
                       e.v[10:9], e.v[8:7], e.v[6:1], e.v[0]);
            end
        end
    endtask

    // Push the state expected after the next edge, clock it, then compare.
    task automatic cyc(input string tag, input int ph, input int st, input int cfg, input int r);
        exp_t e;
        e.tag = tag;
        e.v   = {ph[1:0], st[1:0], cfg[5:0], r[0]};
        sb.push_back(e);
        @(posedge clk_1MHz);
        #1;
        pop_check();
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0);
        #1;
        cyc("rst0", B, 0, 'h00, 0);
        cyc("rst1", B, 0, 'h00, 0);
        rst = 1'b0;
        for (int i = 0; i < BC - 1; i++) cyc("boot_hold", B, 0, 'h00, 0);
        cyc("boot_done", S, 0, 'h00, 0);

        drive(1, 5, 0, 0); cyc("sel_s0", D, 0, 'h05, 0);
        drive(1, 7, 0, 0); cyc("disp_strobe_ign", D, 0, 'h05, 0);
        drive(0, 7, 1, 0); cyc("disp_back_ign", D, 0, 'h05, 0);
        drive(0, 0, 0, 0); cyc("disp_done_s0", S, 1, 'h05, 0);
        drive(0, 0, 1, 0); cyc("back_s1", S, 0, 'h05, 0);
        cyc("back_s0_ign", S, 0, 'h05, 0);
        drive(1, 5, 0, 0); cyc("resel_s0", D, 0, 'h05, 0);
        drive(0, 0, 0, 0);
        cyc("disp_s0_a", D, 0, 'h05, 0);
        cyc("disp_s0_b", D, 0, 'h05, 0);
        cyc("to_s1", S, 1, 'h05, 0);
        drive(1, 2, 1, 0); cyc("strobe_beats_back", D, 1, 'h15, 0);
        drive(0, 0, 0, 0);
        cyc("disp_s1_a", D, 1, 'h15, 0);
        cyc("disp_s1_b", D, 1, 'h15, 0);
        cyc("enter_run", R, 1, 'h15, 1);
        drive(1, 7, 1, 0);
        cyc("run_ign_a", R, 1, 'h15, 1);
        cyc("run_ign_b", R, 1, 'h15, 1);

        drive(0, 0, 0, 1); cyc("restart", S, 0, 'h15, 0);
        cyc("restart_in_select_ign", S, 0, 'h15, 0);
        drive(1, 3, 0, 0); cyc("resel_after_restart", D, 0, 'h13, 0);
        drive(0, 0, 0, 0);
        cyc("disp_r_a", D, 0, 'h13, 0);
        cyc("disp_r_b", D, 0, 'h13, 0);
        cyc("to_s1_r", S, 1, 'h13, 0);
        drive(1, 6, 0, 0); cyc("sel_s1_r", D, 1, 'h33, 0);
        drive(0, 0, 0, 0); cyc("mid_disp", D, 1, 'h33, 0);

        rst = 1'b1; cyc("rst_mid_disp", B, 0, 'h00, 0);
        rst = 1'b0;
        drive(1, 7, 1, 1);
        for (int i = 0; i < BC - 1; i++) cyc("boot2_strobes_ign", B, 0, 'h00, 0);
        drive(0, 3, 0, 0); cyc("boot2_done", S, 0, 'h00, 0);

`ifdef NCO_SEQ_TIMEOUT_EN
        for (int i = 0; i < TC - 1; i++) cyc("idle_wait", S, 0, 'h00, 0);
        cyc("timeout_accept", D, 0, 'h03, 0);
`else
        for (int i = 0; i < 100; i++) cyc("select_hold", S, 0, 'h00, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
